// File: rtl/ram_param.sv
// Parameterized word-addressed RAM with async-clear storage, 1-cycle registered reads,
// out-of-range error pulse and a background fill engine that writes one word per cycle.

module ram_param_word #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module ram_param #(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic              readWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              fill,
  input  logic [WIDTH-1:0]  fillValue,
  output logic [WIDTH-1:0]  dataOut,
  output logic              valid,
  output logic              busy,
  output logic              error
);
  typedef enum logic {IDLE, FILL} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             fill_idx;
  logic [WIDTH-1:0]              pattern;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [DEPTH-1:0]              word_we;
  logic [WIDTH-1:0]              word_d;
  logic [WIDTH-1:0]              rd_data;
  logic                          filling;
  logic                          accept;
  logic                          in_range;

  assign filling  = (state == FILL);
  assign accept   = !filling && enable && !fill;
  // Extra MSB so DEPTH itself is representable when DEPTH is a power of two.
  assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
  assign word_d   = filling ? pattern : dataIn;
  assign busy     = filling;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = filling ? (fill_idx == ADDR_W'(i))
                                : (accept && readWrite && in_range && (address == ADDR_W'(i)));
    ram_param_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .clear (clear),
      .we    (word_we[i]),
      .d     (word_d),
      .q     (mem[i])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (address == ADDR_W'(i)) rd_data = mem[i];
  end

  // fill outranks enable in IDLE; everything is ignored while filling.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      fill_idx <= '0;
      pattern  <= '0;
      dataOut  <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (fill) begin
            pattern  <= fillValue;
            fill_idx <= '0;
            state    <= FILL;
          end else if (enable) begin
            if (!in_range) begin
              error <= 1'b1;
            end else if (!readWrite) begin
              dataOut <= rd_data;
              valid   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (fill_idx == ADDR_W'(DEPTH-1)) begin
            fill_idx <= '0;
            state    <= IDLE;
          end else begin
            fill_idx <= fill_idx + ADDR_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, legal range 1 to 32.
REQ-002 Parameter DEPTH, default 4: number of words, legal range 2 to 256, not required to be a power of two.
REQ-003 Derived ADDR_W = ceil(log2(DEPTH)): address width in bits.
REQ-004 Port clk, input, 1 bit: single clock; all state changes except reset occur on its rising edge.
REQ-005 Port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port enable, input, 1 bit: access request qualifier.
REQ-007 Port readWrite, input, 1 bit: access type; 1 = write, 0 = read.
REQ-008 Port address, input, ADDR_W bits: word index.
REQ-009 Port dataIn, input, WIDTH bits: write data.
REQ-010 Port fill, input, 1 bit: request to write fillValue to every word.
REQ-011 Port fillValue, input, WIDTH bits: pattern used by fill; sampled once, when fill is accepted.
REQ-012 Port dataOut, output, WIDTH bits: registered read data.
REQ-013 Port valid, output, 1 bit: dataOut was updated by the access accepted at the previous edge.
REQ-014 Port busy, output, 1 bit: a fill is in progress.
REQ-015 Port error, output, 1 bit: the access accepted at the previous edge used an address >= DEPTH.

Function
REQ-016 An access SHALL be accepted at a rising edge when enable=1, busy=0 and fill=0.
REQ-017 An accepted write to address < DEPTH SHALL store dataIn into mem[address] at that edge; dataOut and valid=0 follow at that edge.
REQ-018 An accepted read from address < DEPTH SHALL load mem[address] into dataOut and set valid=1 at that edge; latency is 1 cycle.
REQ-019 valid SHALL be a single-cycle pulse; it SHALL be 0 after any edge without an accepted read.
REQ-020 dataOut SHALL hold its last value when no read is accepted.
REQ-021 An access with address >= DEPTH SHALL change no memory word and leave dataOut unchanged; valid=0; error=1 for exactly one cycle.
REQ-022 FSM states are IDLE and FILL; IDLE is entered on reset.
REQ-023 In IDLE, fill=1 at an edge SHALL latch fillValue, reset the fill index to 0 and move to FILL; fill has priority over enable on the same edge, and that access is dropped.
REQ-024 In FILL, each edge SHALL write the latched pattern to mem[index] and increment index; after index DEPTH-1 is written, the FSM returns to IDLE.
REQ-025 busy SHALL be 1 exactly while the FSM is in FILL: DEPTH cycles, starting the cycle after acceptance.
REQ-026 While busy=1, enable and fill SHALL be ignored (not queued); valid and error stay 0; dataOut holds.
REQ-027 fill asserted continuously SHALL start a new fill on the first edge after busy falls.
REQ-028 With the FSM in IDLE and no accepted access, memory and all outputs SHALL be unchanged.

Reset
REQ-029 clear=0 SHALL immediately, without waiting for clk, set every memory word to 0, dataOut=0, valid=0, busy=0, error=0, FSM=IDLE and fill index=0.
REQ-030 Reset asserted mid-fill SHALL abort the fill; after release memory is all zeros and busy=0.
REQ-031 The first access SHALL be accepted at the first rising edge after clear returns to 1.

Verification
REQ-032 Reset then read address 0..DEPTH-1 (defaults) -> dataOut=0000 and valid=1 one cycle after each read.
REQ-033 Write 1001 to address 1, then read address 1 -> dataOut=1001 with a single-cycle valid pulse; address 0 still reads 0000.
REQ-034 DEPTH=3 with ADDR_W=2; write 1111 to address 3 -> error pulses for 1 cycle; reads of addresses 0..2 return 0000.
REQ-035 fill=1 with fillValue=1011 and enable=1 on the same edge -> busy high for 4 cycles; requests during busy are ignored; afterwards all words read 1011.
REQ-036 clear=0 driven between clock edges after 2 fill cycles -> outputs are 0 at once and busy=0; after release all words read 0000.
REQ-037 WIDTH=8, DEPTH=16, random write/read sequence checked against a reference model -> no mismatches; valid count equals the number of accepted in-range reads.
